// File: rtl/reg_wb_queue.sv
// Writeback queue feeding the register-file write port, with a bypass lookup for ID.
// Optional macro WBQ_COALESCE_EN: a push to an address already queued overwrites the youngest copy.
module reg_wb_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       r_clk,
  input  logic                       r_rst,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [AWIDTH-1:0]          wb_addr,
  input  logic [DWIDTH-1:0]          wb_data,
  input  logic                       rf_hold,
  output logic                       r_wr_en,
  output logic [AWIDTH-1:0]          r_addr_in,
  output logic [DWIDTH-1:0]          r_data_in,
  input  logic [AWIDTH-1:0]          lk_addr,
  output logic                       lk_hit,
  output logic [DWIDTH-1:0]          lk_data,
  output logic                       q_empty,
  output logic [$clog2(DEPTH):0]     q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AWIDTH-1:0] addr_q;
  logic [DEPTH-1:0][DWIDTH-1:0] data_q;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;

  logic              full, push, push_nz, pop, append;
  logic              lk_match;
  logic [DWIDTH-1:0] lk_val;
  logic              co_hit;

  assign q_empty  = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign q_count  = cnt_q;
  assign wb_ready = !full;
  assign push     = wb_valid && wb_ready;
  assign push_nz  = push && (wb_addr != '0);
  assign pop      = !q_empty && !rf_hold;
  assign append   = push_nz && !co_hit;

  // Head is driven straight from storage so it is stable for the register file's negedge sample.
  assign r_wr_en   = pop;
  assign r_addr_in = q_empty ? '0 : addr_q[rd_ptr_q];
  assign r_data_in = q_empty ? '0 : data_q[rd_ptr_q];

  // Walk oldest to youngest; the last match wins, giving the youngest copy.
  always_comb begin
    logic [PW-1:0] idx;
    lk_match = 1'b0;
    lk_val   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < cnt_q && addr_q[idx] == lk_addr) begin
        lk_match = 1'b1;
        lk_val   = data_q[idx];
      end
    end
  end

  assign lk_hit  = lk_match && (lk_addr != '0);
  assign lk_data = lk_hit ? lk_val : '0;

`ifdef WBQ_COALESCE_EN
  logic [PW-1:0] co_idx;
  // A head being popped this cycle is already committed to the write port, so skip it.
  always_comb begin
    logic [PW-1:0] idx;
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < cnt_q && !(pop && i == 0) && addr_q[idx] == wb_addr && push_nz) begin
        co_hit = 1'b1;
        co_idx = idx;
      end
    end
  end
`else
  assign co_hit = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (append) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    if (append && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!append && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      addr_q   <= '0;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (append) begin
        addr_q[wr_ptr_q] <= wb_addr;
        data_q[wr_ptr_q] <= wb_data;
      end
`ifdef WBQ_COALESCE_EN
      else if (co_hit) begin
        data_q[co_idx] <= wb_data;
      end
`endif
    end
  end
endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized scoreboard bench for reg_wb_queue; reference model is a queue of pending writes.
module tb_reg_wb_queue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rf_hold = 1'b0;
  logic          r_wr_en;
  logic [AW-1:0] r_addr_in;
  logic [DW-1:0] r_data_in;
  logic [AW-1:0] lk_addr = '0;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
  logic          q_empty;
  logic [CW-1:0] q_count;

  reg_wb_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
    .r_clk(r_clk), .r_rst(r_rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_hold(rf_hold),
    .r_wr_en(r_wr_en), .r_addr_in(r_addr_in), .r_data_in(r_data_in),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .q_empty(q_empty), .q_count(q_count)
  );

  always #5 r_clk = ~r_clk;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];           // pending writes, oldest first
  int   checks = 0;
  int   failures = 0;
  bit   rdy_exp = 1'b1;  // model's view of wb_ready for the cycle ending at the next posedge

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus side of the scoreboard: record accepted pushes.
  always @(posedge r_clk) begin
    if (r_rst && wb_valid && rdy_exp && wb_addr != '0) begin
`ifdef WBQ_COALESCE_EN
      int j;
      j = -1;
      for (int k = 0; k < mq.size(); k++) if (mq[k].a == wb_addr) j = k;
      if (j >= 0) mq[j].d = wb_data;
      else mq.push_back('{a: wb_addr, d: wb_data});
`else
      mq.push_back('{a: wb_addr, d: wb_data});
`endif
    end
  end

  always @(negedge r_rst) mq.delete();

  // Monitor: compare status and lookup, then retire the head when the write port fires.
  always @(negedge r_clk) begin
    bit            we_exp, hit_exp;
    logic [DW-1:0] lkd_exp;
    we_exp  = (mq.size() > 0) && !rf_hold && r_rst;
    hit_exp = 1'b0;
    lkd_exp = '0;
    foreach (mq[k]) if (lk_addr != '0 && mq[k].a == lk_addr) begin hit_exp = 1'b1; lkd_exp = mq[k].d; end
    rdy_exp = mq.size() < DEPTH;
    chk("q_count", q_count, mq.size());
    chk("q_empty", q_empty, mq.size() == 0);
    chk("wb_ready", wb_ready, rdy_exp);
    chk("lk_hit", lk_hit, hit_exp);
    chk("lk_data", lk_data, lkd_exp);
    chk("r_wr_en", r_wr_en, we_exp);
    if (mq.size() > 0) begin
      chk("r_addr_in", r_addr_in, mq[0].a);
      chk("r_data_in", r_data_in, mq[0].d);
    end else begin
      chk("r_addr_in_idle", r_addr_in, 0);
      chk("r_data_in_idle", r_data_in, 0);
    end
    if (we_exp) void'(mq.pop_front());
  end

  task automatic step(input bit v, input int a, input logic [DW-1:0] d, input bit h, input int lk);
    wb_valid = v;
    wb_addr  = AW'(a);
    wb_data  = d;
    rf_hold  = h;
    lk_addr  = AW'(lk);
    @(posedge r_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge r_clk);
    #1 r_rst = 1'b1;
    step(0, 0, 0, 0, 0);

    // single write
    step(1, 5, 32'hDEADBEEF, 0, 5);
    repeat (3) step(0, 0, 0, 0, 5);

    // fill under hold, stalled fifth push, then release
    for (int i = 1; i <= 4; i++) step(1, i, 32'h100 + i, 1, i);
    repeat (2) step(1, 9, 32'h999, 1, 9);
    repeat (6) step(0, 0, 0, 0, 2);

    // youngest bypass / coalesce
    step(1, 7, 32'h11, 1, 7);
    step(1, 7, 32'h22, 1, 7);
    step(0, 0, 0, 1, 7);
    repeat (4) step(0, 0, 0, 0, 7);

    // zero register
    step(1, 0, 32'hFFFF, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);

    // streaming push/pop across pointer wrap
    for (int i = 1; i <= 10; i++) step(1, i, 32'h1000 * i, 0, i);
    repeat (2) step(0, 0, 0, 0, 3);

    // reset mid-operation
    for (int i = 1; i <= 3; i++) step(1, 10 + i, 32'hA0 + i, 1, 11);
    wb_valid = 1'b0;
    r_rst = 1'b0;
    #1;
    chk("rst_wr_en", r_wr_en, 0);
    chk("rst_addr", r_addr_in, 0);
    chk("rst_data", r_data_in, 0);
    chk("rst_empty", q_empty, 1);
    chk("rst_count", q_count, 0);
    chk("rst_ready", wb_ready, 1);
    chk("rst_lk_hit", lk_hit, 0);
    #1 r_rst = 1'b1;
    repeat (4) step(0, 0, 0, 0, 12);

    // random traffic
    for (int n = 0; n < 500; n++)
      step(($urandom % 3) != 0, $urandom % 8, $urandom, ($urandom % 4) == 0, $urandom % 8);
    repeat (8) step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-side master for the register file: buffers writeback requests from the pipeline's WB stage and drains them, one per cycle, onto the register-file write port (r_wr_en / r_addr_in / r_data_in).
- Provides a read-bypass lookup so the ID stage sees queued-but-unwritten values.
- Decouples WB bursts (e.g. ALU result and load return in the same window) from the single write port.

Parameters:
- DWIDTH, 32, data width; matches register file data width.
- AWIDTH, 5, register address width; matches register file address width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- r_clk  input  1  clock; all state updates on posedge.
- r_rst  input  1  reset, asynchronous, active-low.
- wb_valid  input  1  WB request valid.
- wb_ready  output  1  queue can accept a request.
- wb_addr  input  AWIDTH  destination register.
- wb_data  input  DWIDTH  write data.
- rf_hold  input  1  suppress draining this cycle (e.g. register-file test access).
- r_wr_en  output  1  register-file write enable.
- r_addr_in  output  AWIDTH  register-file write address.
- r_data_in  output  DWIDTH  register-file write data.
- lk_addr  input  AWIDTH  bypass lookup address.
- lk_hit  output  1  lk_addr matches a queued entry.
- lk_data  output  DWIDTH  data of the youngest matching entry.
- q_empty  output  1  no entries queued.
- q_count  output  clog2(DEPTH)+1  occupancy, 0..DEPTH.

Behaviour:
- Reset (r_rst low, any time, including mid-drain):
  - All entries invalid; read/write pointers 0; count 0.
  - r_wr_en=0, r_addr_in=0, r_data_in=0, lk_hit=0, lk_data=0, q_empty=1, q_count=0, wb_ready=1.
  - Queued writes are discarded.
- Storage: circular buffer of DEPTH {addr, data} entries; wr_ptr/rd_ptr wrap modulo DEPTH.
- Push handshake:
  - Transfer occurs at posedge when wb_valid && wb_ready.
  - wb_ready = (count != DEPTH); it does not depend on same-cycle pop (no pass-through when full).
  - wb_addr == 0: handshake completes, nothing is enqueued ($0 is never written).
- Drain:
  - r_wr_en = !q_empty && !rf_hold.
  - r_addr_in / r_data_in = head entry when !q_empty, else 0.
  - Outputs come from registered storage; they are stable for the whole cycle, so the register file's negedge sample is safe.
  - Pop occurs at the posedge ending any cycle with r_wr_en=1.
  - Latency: a push into an empty queue reaches the write port (r_wr_en=1) in the next cycle; a 1-entry burst takes 2 cycles from handshake to register-file write.
- Simultaneous push and pop: both happen; count unchanged.
- Ordering: strictly FIFO; multiple writes to the same address all drain in order.
- Bypass lookup (combinational):
  - Searches all valid entries, including the head currently being written.
  - lk_hit=1 if any entry addr == lk_addr; lk_data = data of the youngest (most recently pushed) match.
  - lk_addr == 0 never hits.
  - lk_data = 0 when lk_hit = 0.
  - Same-cycle incoming wb_data is not visible until after the push edge.
- count/q_count: +1 on push-only, -1 on pop-only, never exceeds DEPTH or underflows.
- rf_hold held high: queue fills to DEPTH, then wb_ready=0; draining resumes the cycle after rf_hold falls.

Optional Feature:
- Macro: WBQ_COALESCE_EN.
- Defined:
  - A push whose addr matches a valid entry overwrites the youngest matching entry's data in place; count unchanged.
  - The head entry is never a coalesce target in a cycle where it is being popped; in that case the push appends normally.
  - wb_ready is unchanged (still !full).
- Not defined: every accepted non-zero push appends a new entry.

Test Plan:
- Single write: push addr=5 data=0xDEADBEEF into empty queue -> next cycle r_wr_en=1, r_addr_in=5, r_data_in=0xDEADBEEF; following cycle q_empty=1, r_wr_en=0.
- Fill/backpressure: rf_hold=1, push addrs 1,2,3,4 -> q_count=4, wb_ready=0; fifth push stalls. Release rf_hold -> writes 1,2,3,4 on four consecutive cycles; wb_ready=1 after the first pop.
- Bypass youngest:
  - Without WBQ_COALESCE_EN: rf_hold=1, push (7,0x11) then (7,0x22), lk_addr=7 -> lk_hit=1, lk_data=0x22; on drain, addr 7 is written 0x11 then 0x22.
  - With WBQ_COALESCE_EN: same stimulus -> q_count=1, single write of 0x22.
- Zero register: push addr=0 data=0xFFFF -> handshake completes, q_count stays 0, r_wr_en never asserts; lk_addr=0 -> lk_hit=0.
- Simultaneous push/pop with wrap: steady wb_valid with rf_hold=0 for 10 cycles, addrs 1..10 -> q_count constant at 1, writes in order, pointers wrap without loss.
- Reset mid-operation: 3 entries queued, r_rst pulsed low between edges -> outputs immediately 0, q_empty=1; after release the old entries are never written.
